dram_req_gate: RTL and testbench

AXI4 request gate and transaction tracker in the `soc_clk` domain, between the SoC DRAM master port and the SoC→DRAM AXI CDC. It holds off all DRAM traffic until DRAM calibration completes. It counts outstanding reads and writes and caps them, and it drains the port cleanly on request. An optional watchdog flags a DRAM port that stops responding.

---
 rtl/dram_req_gate.sv | 233 +++++++++++++++++++++++
 tb/tb_dram_req_gate.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_req_gate.sv
// AXI4 request gate / outstanding-transaction tracker between the SoC DRAM port and the AXI CDC.
// Optional watchdog compiled in with `define DRAM_REQ_GATE_TIMEOUT_EN.
package dram_req_gate_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } axi_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    axi_b_t  b;
    logic    b_valid;
    axi_r_t  r;
    logic    r_valid;
  } axi_resp_t;
endpackage

// Default struct types come from dram_req_gate_pkg so the block elaborates standalone;
// integrators override axi_req_t/axi_resp_t with the CDC port types (same field names).
module dram_req_gate #(
  parameter int unsigned MaxTxns       = 16,
  parameter int unsigned TimeoutCycles = 65536,
  parameter type         axi_req_t     = dram_req_gate_pkg::axi_req_t,
  parameter type         axi_resp_t    = dram_req_gate_pkg::axi_resp_t,
  localparam int unsigned CntW         = $clog2(MaxTxns + 1)
) (
  input  logic            soc_clk,
  input  logic            rst_n,
  input  logic            calib_done_i,
  input  logic            drain_req_i,
  input  axi_req_t        slv_req_i,
  output axi_resp_t       slv_resp_o,
  output axi_req_t        mst_req_o,
  input  axi_resp_t       mst_resp_i,
  output logic            ready_o,
  output logic            idle_o,
  output logic            timeout_o,
  output logic [CntW-1:0] rd_cnt_o,
  output logic [CntW-1:0] wr_cnt_o,
  output logic [1:0]      dbg_state_o
);

  if (MaxTxns < 1) begin : g_bad_max_txns
    $error("dram_req_gate: MaxTxns must be at least 1");
  end
  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("dram_req_gate: TimeoutCycles must be at least 2");
  end

  typedef enum logic [1:0] {
    WaitCalib = 2'd0,
    Run       = 2'd1,
    Drain     = 2'd2,
    Drained   = 2'd3
  } state_e;

  localparam logic [CntW-1:0] CntMax = CntW'(MaxTxns);

  state_e          state_q;
  logic            ready_q, idle_q;
  logic            calib_q1, calib_s;
  logic [CntW-1:0] rd_cnt_q, wr_cnt_q;
  logic            allow_aw, allow_ar, allow_w;
  logic            aw_hs, ar_hs, b_hs, r_hs, r_last_hs;

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_q1 <= 1'b0;
      calib_s  <= 1'b0;
    end else begin
      calib_q1 <= calib_done_i;
      calib_s  <= calib_q1;
    end
  end

  // Gating looks only at registered state/counters, so a cap or drain takes effect next cycle.
  assign allow_aw = (state_q == Run) && (wr_cnt_q != CntMax);
  assign allow_ar = (state_q == Run) && (rd_cnt_q != CntMax);
  assign allow_w  = (state_q != WaitCalib);

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = slv_req_i.aw_valid & allow_aw;
    mst_req_o.w_valid  = slv_req_i.w_valid  & allow_w;
    mst_req_o.ar_valid = slv_req_i.ar_valid & allow_ar;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & allow_aw;
    slv_resp_o.w_ready  = mst_resp_i.w_ready  & allow_w;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & allow_ar;
  end

  assign aw_hs     = slv_req_i.aw_valid & allow_aw & mst_resp_i.aw_ready;
  assign ar_hs     = slv_req_i.ar_valid & allow_ar & mst_resp_i.ar_ready;
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign r_hs      = mst_resp_i.r_valid & slv_req_i.r_ready;
  assign r_last_hs = r_hs & mst_resp_i.r.last;

  // A stray decrement at zero is a protocol violation; hold at zero rather than wrap.
  function automatic logic [CntW-1:0] next_cnt(input logic [CntW-1:0] cnt,
                                               input logic inc, input logic dec);
    logic [CntW-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + CntW'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      res = cnt - CntW'(1);
    end
    return res;
  endfunction

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= next_cnt(rd_cnt_q, ar_hs, r_last_hs);
      wr_cnt_q <= next_cnt(wr_cnt_q, aw_hs, b_hs);
    end
  end

  // Dropping drain_req_i while draining returns to Run even if the counters just hit zero.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WaitCalib;
      ready_q <= 1'b0;
      idle_q  <= 1'b0;
    end else begin
      unique case (state_q)
        WaitCalib: begin
          if (calib_s) begin
            state_q <= Run;
            ready_q <= 1'b1;
          end
        end
        Run: begin
          if (drain_req_i) begin
            state_q <= Drain;
            ready_q <= 1'b0;
          end
        end
        Drain: begin
          if (!drain_req_i) begin
            state_q <= Run;
            ready_q <= 1'b1;
          end else if ((rd_cnt_q == '0) && (wr_cnt_q == '0)) begin
            state_q <= Drained;
            idle_q  <= 1'b1;
          end
        end
        Drained: begin
          if (!drain_req_i) begin
            state_q <= Run;
            ready_q <= 1'b1;
            idle_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= WaitCalib;
          ready_q <= 1'b0;
          idle_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DRAM_REQ_GATE_TIMEOUT_EN
  localparam int unsigned   WdW   = $clog2(TimeoutCycles);
  localparam logic [WdW-1:0] WdMax = WdW'(TimeoutCycles - 1);

  logic [WdW-1:0] wd_q;
  logic           timeout_q;

  // Any response proves the port is alive; with nothing outstanding there is nothing to wait for.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (b_hs || r_hs || ((rd_cnt_q == '0) && (wr_cnt_q == '0))) begin
        wd_q <= '0;
      end else if (wd_q != WdMax) begin
        wd_q <= wd_q + WdW'(1);
      end
      if (wd_q == WdMax) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign ready_o     = ready_q;
  assign idle_o      = idle_q;
  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dram_req_gate.sv
// Bench for dram_req_gate: directed scenarios then random traffic, checked against a
// cycle-level behavioural model of the gate's rules (MaxTxns=4, TimeoutCycles=64).
`timescale 1ns/1ps
module tb_dram_req_gate;
  import dram_req_gate_pkg::*;

  localparam int unsigned MaxTxns       = 4;
  localparam int unsigned TimeoutCycles = 64;
  localparam int unsigned CntW          = $clog2(MaxTxns + 1);

  // ---------------- clock / reset ----------------
  logic soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  logic            rst_n;
  logic            calib_done_i;
  logic            drain_req_i;
  axi_req_t        slv_req_i;
  axi_resp_t       slv_resp_o;
  axi_req_t        mst_req_o;
  axi_resp_t       mst_resp_i;
  logic            ready_o;
  logic            idle_o;
  logic            timeout_o;
  logic [CntW-1:0] rd_cnt_o;
  logic [CntW-1:0] wr_cnt_o;
  logic [1:0]      dbg_state_o;

  dram_req_gate #(
    .MaxTxns      (MaxTxns),
    .TimeoutCycles(TimeoutCycles),
    .axi_req_t    (axi_req_t),
    .axi_resp_t   (axi_resp_t)
  ) dut (
    .soc_clk     (soc_clk),
    .rst_n       (rst_n),
    .calib_done_i(calib_done_i),
    .drain_req_i (drain_req_i),
    .slv_req_i   (slv_req_i),
    .slv_resp_o  (slv_resp_o),
    .mst_req_o   (mst_req_o),
    .mst_resp_i  (mst_resp_i),
    .ready_o     (ready_o),
    .idle_o      (idle_o),
    .timeout_o   (timeout_o),
    .rd_cnt_o    (rd_cnt_o),
    .wr_cnt_o    (wr_cnt_o),
    .dbg_state_o (dbg_state_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  bit m_sync1, m_sync2;   // calib_done_i delayed by 1 and 2 edges
  bit m_up;               // calibration seen, gate has left its startup hold
  bit m_draining;
  bit m_idle;
  bit m_to;
  int m_rd, m_wr;
  int m_stall;            // consecutive edges with work outstanding and no response
  bit seen_ar_valid;

  function automatic bit m_run();
    return m_up && !m_draining && !m_idle;
  endfunction
  function automatic bit m_allow_aw();
    return m_run() && (m_wr < MaxTxns);
  endfunction
  function automatic bit m_allow_ar();
    return m_run() && (m_rd < MaxTxns);
  endfunction
  function automatic bit m_allow_w();
    return m_up;
  endfunction

  task automatic model_reset();
    m_sync1 = 0; m_sync2 = 0; m_up = 0; m_draining = 0; m_idle = 0; m_to = 0;
    m_rd = 0; m_wr = 0; m_stall = 0;
  endtask

  task automatic model_edge();
    bit aw_hs, ar_hs, b_hs, r_hs, r_last, busy;
    int rd_n, wr_n;
    aw_hs  = slv_req_i.aw_valid && mst_resp_i.aw_ready && m_allow_aw();
    ar_hs  = slv_req_i.ar_valid && mst_resp_i.ar_ready && m_allow_ar();
    b_hs   = mst_resp_i.b_valid && slv_req_i.b_ready;
    r_hs   = mst_resp_i.r_valid && slv_req_i.r_ready;
    r_last = r_hs && mst_resp_i.r.last;
    busy   = (m_rd != 0) || (m_wr != 0);
    rd_n = m_rd + int'(ar_hs) - int'(r_last);
    wr_n = m_wr + int'(aw_hs) - int'(b_hs);
    if (rd_n < 0) rd_n = 0;
    if (wr_n < 0) wr_n = 0;
    if (!m_up) begin
      m_up = m_sync2;
    end else if (m_run()) begin
      if (drain_req_i) m_draining = 1;
    end else if (m_draining) begin
      if (!drain_req_i) m_draining = 0;
      else if (!busy) begin m_draining = 0; m_idle = 1; end
    end else if (m_idle && !drain_req_i) begin
      m_idle = 0;
    end
`ifdef DRAM_REQ_GATE_TIMEOUT_EN
    if (m_stall >= int'(TimeoutCycles) - 1) m_to = 1;
    if (b_hs || r_hs || !busy) m_stall = 0;
    else m_stall++;
`endif
    m_sync2 = m_sync1;
    m_sync1 = calib_done_i;
    m_rd = rd_n;
    m_wr = wr_n;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("mst_aw_valid", 64'(mst_req_o.aw_valid), 64'(slv_req_i.aw_valid & m_allow_aw()));
    chk("slv_aw_ready", 64'(slv_resp_o.aw_ready), 64'(mst_resp_i.aw_ready & m_allow_aw()));
    chk("mst_w_valid", 64'(mst_req_o.w_valid), 64'(slv_req_i.w_valid & m_allow_w()));
    chk("slv_w_ready", 64'(slv_resp_o.w_ready), 64'(mst_resp_i.w_ready & m_allow_w()));
    chk("mst_ar_valid", 64'(mst_req_o.ar_valid), 64'(slv_req_i.ar_valid & m_allow_ar()));
    chk("slv_ar_ready", 64'(slv_resp_o.ar_ready), 64'(mst_resp_i.ar_ready & m_allow_ar()));
    chk("ar_addr", 64'(mst_req_o.ar.addr), 64'(slv_req_i.ar.addr));
    chk("aw_addr", 64'(mst_req_o.aw.addr), 64'(slv_req_i.aw.addr));
    chk("w_data", 64'(mst_req_o.w.data), 64'(slv_req_i.w.data));
    chk("r_data", 64'(slv_resp_o.r.data), 64'(mst_resp_i.r.data));
    chk("r_valid", 64'(slv_resp_o.r_valid), 64'(mst_resp_i.r_valid));
    chk("b_valid", 64'(slv_resp_o.b_valid), 64'(mst_resp_i.b_valid));
    chk("r_ready", 64'(mst_req_o.r_ready), 64'(slv_req_i.r_ready));
    chk("b_ready", 64'(mst_req_o.b_ready), 64'(slv_req_i.b_ready));
    chk("ready_o", 64'(ready_o), 64'(m_run()));
    chk("idle_o", 64'(idle_o), 64'(m_idle));
    chk("timeout_o", 64'(timeout_o), 64'(m_to));
    chk("rd_cnt_o", 64'(rd_cnt_o), 64'(m_rd));
    chk("wr_cnt_o", 64'(wr_cnt_o), 64'(m_wr));
  endtask

  // ---------------- driver tasks ----------------
  // Called right after a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick();
    #1;
    seen_ar_valid = mst_req_o.ar_valid;
    check_all();
    @(posedge soc_clk);
    model_edge();
    @(negedge soc_clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rand_payload();
    slv_req_i.aw.addr  = $urandom;
    slv_req_i.aw.id    = 4'($urandom_range(0, 15));
    slv_req_i.aw.len   = 8'($urandom_range(0, 255));
    slv_req_i.ar.addr  = $urandom;
    slv_req_i.ar.id    = 4'($urandom_range(0, 15));
    slv_req_i.ar.len   = 8'($urandom_range(0, 255));
    slv_req_i.w.data   = $urandom;
    slv_req_i.w.strb   = 4'($urandom_range(0, 15));
    slv_req_i.w.last   = 1'($urandom_range(0, 1));
    mst_resp_i.r.data  = $urandom;
    mst_resp_i.r.id    = 4'($urandom_range(0, 15));
    mst_resp_i.r.resp  = 2'($urandom_range(0, 3));
    mst_resp_i.b.id    = 4'($urandom_range(0, 15));
    mst_resp_i.b.resp  = 2'($urandom_range(0, 3));
  endtask

  task automatic quiet_inputs();
    slv_req_i  = '0;
    mst_resp_i = '0;
    slv_req_i.b_ready   = 1'b1;
    slv_req_i.r_ready   = 1'b1;
    mst_resp_i.aw_ready = 1'b1;
    mst_resp_i.ar_ready = 1'b1;
    mst_resp_i.w_ready  = 1'b1;
    rand_payload();
  endtask

  task automatic rand_cycle_inputs();
    rand_payload();
    slv_req_i.aw_valid  = 1'($urandom_range(0, 1));
    slv_req_i.ar_valid  = 1'($urandom_range(0, 1));
    slv_req_i.w_valid   = 1'($urandom_range(0, 1));
    slv_req_i.b_ready   = 1'($urandom_range(0, 1));
    slv_req_i.r_ready   = 1'($urandom_range(0, 1));
    mst_resp_i.aw_ready = 1'($urandom_range(0, 1));
    mst_resp_i.ar_ready = 1'($urandom_range(0, 1));
    mst_resp_i.w_ready  = 1'($urandom_range(0, 1));
    mst_resp_i.b_valid  = ($urandom_range(0, 3) == 0);
    mst_resp_i.r_valid  = ($urandom_range(0, 2) == 0);
    mst_resp_i.r.last   = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 15) == 0) drain_req_i = ~drain_req_i;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 64'(ready_o), 64'd0);
    chk({tag, "_idle"}, 64'(idle_o), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout_o), 64'd0);
    chk({tag, "_rd_cnt"}, 64'(rd_cnt_o), 64'd0);
    chk({tag, "_wr_cnt"}, 64'(wr_cnt_o), 64'd0);
    chk({tag, "_ar_valid"}, 64'(mst_req_o.ar_valid), 64'd0);
    chk({tag, "_aw_valid"}, 64'(mst_req_o.aw_valid), 64'd0);
    chk({tag, "_w_valid"}, 64'(mst_req_o.w_valid), 64'd0);
    chk({tag, "_ar_ready"}, 64'(slv_resp_o.ar_ready), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int lat;
    rst_n        = 1'b0;
    calib_done_i = 1'b0;
    drain_req_i  = 1'b0;
    quiet_inputs();
    slv_req_i.aw_valid = 1'b1;
    slv_req_i.ar_valid = 1'b1;
    slv_req_i.w_valid  = 1'b1;
    model_reset();
    repeat (3) @(posedge soc_clk);
    @(negedge soc_clk);
    check_reset_values("por");
    rst_n = 1'b1;
    quiet_inputs();

    // 1: calibration hold, then 3-cycle release of AR
    slv_req_i.ar_valid = 1'b1;
    slv_req_i.ar.addr  = 32'h8000_0000;
    ticks(6);
    chk("calib_hold_ar_valid", 64'(mst_req_o.ar_valid), 64'd0);
    calib_done_i = 1'b1;
    lat = -1;
    for (int k = 0; k < 8 && lat < 0; k++) begin
      tick();
      if (seen_ar_valid) lat = k;
    end
    chk("calib_latency", 64'(lat), 64'd3);
    chk("calib_rd_cnt", 64'(rd_cnt_o), 64'd1);
    slv_req_i.ar_valid = 1'b0;

    // 2: write cap with B held off
    slv_req_i.aw_valid = 1'b1;
    slv_req_i.b_ready  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      slv_req_i.w_valid = 1'($urandom_range(0, 1));
      slv_req_i.aw.addr = $urandom;
      tick();
    end
    chk("cap_wr_cnt", 64'(wr_cnt_o), 64'd4);
    chk("cap_aw_stalled", 64'(mst_req_o.aw_valid), 64'd0);
    mst_resp_i.b_valid = 1'b1;
    tick();
    mst_resp_i.b_valid = 1'b0;
    chk("cap_after_b_wr_cnt", 64'(wr_cnt_o), 64'd3);
    chk("cap_fifth_passes", 64'(mst_req_o.aw_valid), 64'd1);
    tick();
    chk("cap_refilled_wr_cnt", 64'(wr_cnt_o), 64'd4);
    slv_req_i.aw_valid = 1'b0;
    slv_req_i.w_valid  = 1'b0;
    tick();

    // 3: simultaneous AR accept and R last; non-last R beat
    slv_req_i.ar_valid = 1'b1;
    mst_resp_i.r_valid = 1'b1;
    mst_resp_i.r.last  = 1'b1;
    tick();
    chk("simul_rd_cnt", 64'(rd_cnt_o), 64'd1);
    slv_req_i.ar_valid = 1'b0;
    mst_resp_i.r.last  = 1'b0;
    tick();
    chk("nonlast_rd_cnt", 64'(rd_cnt_o), 64'd1);
    mst_resp_i.r_valid = 1'b0;

    // 4: drain with 2 reads and 1 write outstanding
    mst_resp_i.b_valid = 1'b1;
    ticks(3);
    mst_resp_i.b_valid = 1'b0;
    slv_req_i.ar_valid = 1'b1;
    tick();
    slv_req_i.ar_valid = 1'b0;
    chk("pre_drain_rd", 64'(rd_cnt_o), 64'd2);
    chk("pre_drain_wr", 64'(wr_cnt_o), 64'd1);
    drain_req_i = 1'b1;
    tick();
    slv_req_i.aw_valid = 1'b1;
    slv_req_i.ar_valid = 1'b1;
    slv_req_i.w_valid  = 1'b1;
    ticks(3);
    chk("drain_aw_blocked", 64'(mst_req_o.aw_valid), 64'd0);
    chk("drain_ar_blocked", 64'(mst_req_o.ar_valid), 64'd0);
    chk("drain_w_flows", 64'(mst_req_o.w_valid), 64'd1);
    slv_req_i.aw_valid = 1'b0;
    slv_req_i.ar_valid = 1'b0;
    slv_req_i.w_valid  = 1'b0;
    mst_resp_i.r_valid = 1'b1;
    mst_resp_i.r.last  = 1'b1;
    mst_resp_i.b_valid = 1'b1;
    tick();
    mst_resp_i.b_valid = 1'b0;
    tick();
    mst_resp_i.r_valid = 1'b0;
    chk("drain_counts_zero_idle", 64'(idle_o), 64'd0);
    tick();
    chk("drain_idle", 64'(idle_o), 64'd1);
    drain_req_i = 1'b0;
    tick();
    chk("undrain_ready", 64'(ready_o), 64'd1);

    // 5: watchdog on a read that never returns
    slv_req_i.ar_valid = 1'b1;
    tick();
    slv_req_i.ar_valid = 1'b0;
    ticks(60);
    chk("wd_early", 64'(timeout_o), 64'd0);
    ticks(10);
`ifdef DRAM_REQ_GATE_TIMEOUT_EN
    chk("wd_fired", 64'(timeout_o), 64'd1);
`else
    chk("wd_absent", 64'(timeout_o), 64'd0);
`endif
    mst_resp_i.r_valid = 1'b1;
    mst_resp_i.r.last  = 1'b1;
    tick();
    mst_resp_i.r_valid = 1'b0;
    ticks(3);
    chk("wd_rd_back_to_zero", 64'(rd_cnt_o), 64'd0);

    // 6: asynchronous reset with work outstanding
    slv_req_i.ar_valid = 1'b1;
    slv_req_i.aw_valid = 1'b1;
    ticks(2);
    chk("mid_rd_nonzero", 64'(rd_cnt_o != 0), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("async_rst");
    @(posedge soc_clk);
    @(negedge soc_clk);
    check_reset_values("held_rst");
    rst_n = 1'b1;
    ticks(2);
    chk("post_rst_hold_ar", 64'(mst_req_o.ar_valid), 64'd0);
    ticks(4);
    chk("post_rst_running", 64'(ready_o), 64'd1);
    slv_req_i.ar_valid = 1'b0;
    slv_req_i.aw_valid = 1'b0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_cycle_inputs();
      tick();
    end
    quiet_inputs();
    drain_req_i = 1'b0;
    ticks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
